fm_param_slew: RTL and testbench



---
 rtl/fm_param_slew.sv | 183 ++++++++++++++++++
 tb/tb_fm_param_slew.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fm_param_slew.sv
// FM synth parameter conditioner: snapshots button offsets on each sample strobe, saturates and
// slew-limits carrier FCW, modulator FCW and gain, then publishes them together. Macro: FM_SLEW_LIMIT_EN.
module fm_param_slew #(
    parameter logic [31:0] CARRIER_BASE_FCW = 32'd18898,
    parameter logic [31:0] MOD_BASE_FCW     = 32'd9449,
    parameter logic [31:0] FCW_MAX          = 32'h7FFF_FFFF,
    parameter logic [31:0] SLEW_FCW         = 32'd64,
    parameter logic [15:0] GAIN_SLEW        = 16'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [31:0] carrier_offset,
    input  logic [31:0] mod_fcw_offset,
    input  logic [1:0]  vol_step,
    output logic [31:0] carrier_fcw,
    output logic [31:0] mod_fcw,
    output logic [15:0] gain,
    output logic        param_valid,
    output logic        overrun
);

`ifdef FM_SLEW_LIMIT_EN
    localparam logic SLEW_ON = 1'b1;
`else
    localparam logic SLEW_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAR  = 3'd1,
        S_MOD  = 3'd2,
        S_GAIN = 3'd3,
        S_PUB  = 3'd4
    } state_t;

    function automatic logic [31:0] sat_fcw(input logic [31:0] base, input logic [31:0] offset);
        logic [32:0] sum;
        sum = {1'b0, base} + {offset[31], offset};
        if (sum[32])
            sat_fcw = 32'd0;
        else if (sum[31:0] > FCW_MAX)
            sat_fcw = FCW_MAX;
        else
            sat_fcw = sum[31:0];
    endfunction

    // An all-ones step makes every distance "close enough", so the target loads directly.
    function automatic logic [31:0] slew_to(input logic [31:0] cur, input logic [31:0] tgt,
                                            input logic [31:0] step);
        logic [32:0] c;
        logic [32:0] t;
        logic [32:0] s;
        logic [32:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        s = {1'b0, step};
        if (t >= c) begin
            if ((t - c) <= s) r = t;
            else              r = c + s;
        end else begin
            if ((c - t) <= s) r = t;
            else              r = c - s;
        end
        slew_to = r[31:0];
    endfunction

    function automatic logic [15:0] gain_lut(input logic [1:0] idx);
        case (idx)
            2'd0:    gain_lut = 16'h2000;
            2'd1:    gain_lut = 16'h4000;
            2'd2:    gain_lut = 16'h6000;
            2'd3:    gain_lut = 16'h7FFF;
            default: gain_lut = 16'h0000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] car_off_q, mod_off_q;
    logic [1:0]  vol_q;
    logic [31:0] car_work_q, mod_work_q;
    logic [15:0] gain_work_q;
    logic [31:0] car_fcw_q, mod_fcw_q;
    logic [15:0] gain_q;
    logic        valid_q, overrun_q;
    logic        snap_s, ld_car_s, ld_mod_s, ld_gain_s;
    logic [31:0] cur_s, tgt_s, step_s, next_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = sample_tick ? S_CAR : S_IDLE;
            S_CAR:   state_d = S_MOD;
            S_MOD:   state_d = S_GAIN;
            S_GAIN:  state_d = S_PUB;
            S_PUB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode; publish regs load at the end of GAIN so they are visible during PUB
    always_comb begin
        snap_s    = 1'b0;
        ld_car_s  = 1'b0;
        ld_mod_s  = 1'b0;
        ld_gain_s = 1'b0;
        case (state_q)
            S_IDLE:  snap_s    = sample_tick;
            S_CAR:   ld_car_s  = 1'b1;
            S_MOD:   ld_mod_s  = 1'b1;
            S_GAIN:  ld_gain_s = 1'b1;
            S_PUB:   snap_s    = 1'b0;
            default: snap_s    = 1'b0;
        endcase
    end

    // Shared saturate + slew datapath, operand set chosen by state
    always_comb begin
        cur_s  = car_work_q;
        tgt_s  = sat_fcw(CARRIER_BASE_FCW, car_off_q);
        step_s = SLEW_FCW;
        case (state_q)
            S_MOD: begin
                cur_s = mod_work_q;
                tgt_s = sat_fcw(MOD_BASE_FCW, mod_off_q);
            end
            S_GAIN: begin
                cur_s  = {16'd0, gain_work_q};
                tgt_s  = {16'd0, gain_lut(vol_q)};
                step_s = {16'd0, GAIN_SLEW};
            end
            default: cur_s = car_work_q;
        endcase
        next_s = slew_to(cur_s, tgt_s, SLEW_ON ? step_s : 32'hFFFF_FFFF);
    end

    // Snapshot, working and published registers
    always_ff @(posedge clk) begin
        if (reset) begin
            car_off_q   <= 32'd0;
            mod_off_q   <= 32'd0;
            vol_q       <= 2'd0;
            car_work_q  <= CARRIER_BASE_FCW;
            mod_work_q  <= MOD_BASE_FCW;
            gain_work_q <= 16'd0;
            car_fcw_q   <= CARRIER_BASE_FCW;
            mod_fcw_q   <= MOD_BASE_FCW;
            gain_q      <= 16'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (snap_s) begin
                car_off_q <= carrier_offset;
                mod_off_q <= mod_fcw_offset;
                vol_q     <= vol_step;
            end
            if (ld_car_s)  car_work_q  <= next_s;
            if (ld_mod_s)  mod_work_q  <= next_s;
            if (ld_gain_s) begin
                gain_work_q <= next_s[15:0];
                car_fcw_q   <= car_work_q;
                mod_fcw_q   <= mod_work_q;
                gain_q      <= next_s[15:0];
            end
            valid_q   <= ld_gain_s;
            overrun_q <= overrun_q | (sample_tick & (state_q != S_IDLE));
        end
    end

    assign carrier_fcw = car_fcw_q;
    assign mod_fcw     = mod_fcw_q;
    assign gain        = gain_q;
    assign param_valid = valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fm_param_slew.sv
// Directed self-checking bench for fm_param_slew; expectations follow FM_SLEW_LIMIT_EN.
module tb_fm_param_slew;

`ifdef FM_SLEW_LIMIT_EN
    localparam int SLEW = 1;
`else
    localparam int SLEW = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [31:0] carrier_offset;
    logic [31:0] mod_fcw_offset;
    logic [1:0]  vol_step;
    logic [31:0] carrier_fcw;
    logic [31:0] mod_fcw;
    logic [15:0] gain;
    logic        param_valid;
    logic        overrun;

    int n_total = 0;
    int n_pass  = 0;

    fm_param_slew dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .carrier_offset (carrier_offset),
        .mod_fcw_offset (mod_fcw_offset),
        .vol_step       (vol_step),
        .carrier_fcw    (carrier_fcw),
        .mod_fcw        (mod_fcw),
        .gain           (gain),
        .param_valid    (param_valid),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Tick now (cycle N); return at cycle N+5 with the observed publish latency (0 = timeout).
    task automatic do_tick(output int lat);
        lat = 0;
        sample_tick = 1'b1;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            step_cyc();
            sample_tick = 1'b0;
            if (param_valid) lat = i;
        end
        step_cyc();
    endtask

    int lat, e, v1, v2, nv;

    initial begin
        reset = 1'b1; sample_tick = 1'b0;
        carrier_offset = 32'd0; mod_fcw_offset = 32'd0; vol_step = 2'd0;
        step_cyc(); step_cyc();
        reset = 1'b0;
        check("rst_car",     carrier_fcw, 32'd18898);
        check("rst_mod",     mod_fcw, 32'd9449);
        check("rst_gain",    {16'd0, gain}, 32'd0);
        check("rst_valid",   {31'd0, param_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // first publish, latency and single-cycle pulse
        do_tick(lat);
        check("lat1",   lat, 32'd4);
        check("pv_one", {31'd0, param_valid}, 32'd0);
        check("t1_car", carrier_fcw, 32'd18898);
        check("t1_mod", mod_fcw, 32'd9449);
        check("t1_gain", {16'd0, gain}, (SLEW != 0) ? 32'd64 : 32'h2000);

        // carrier rises toward 19898
        carrier_offset = 32'd1000;
        for (int k = 1; k <= 20; k++) begin
            do_tick(lat);
            e = (SLEW != 0) ? ((18898 + 64 * k > 19898) ? 19898 : 18898 + 64 * k) : 19898;
            check("up_car", carrier_fcw, e);
            check("up_mod", mod_fcw, 32'd9449);
        end

        // negative saturation, no wrap below zero
        carrier_offset = -32'sd40000;
        for (int k = 1; k <= 320; k++) begin
            do_tick(lat);
            e = (SLEW != 0) ? ((19898 > 64 * k) ? 19898 - 64 * k : 0) : 0;
            check("dn_car", carrier_fcw, e);
        end

        // gain to full scale, then fall to the vol 0 level
        vol_step = 2'd3;
        for (int k = 1; k <= 400; k++) do_tick(lat);
        check("gain_max", {16'd0, gain}, 32'h7FFF);
        vol_step = 2'd0;
        for (int k = 1; k <= 390; k++) begin
            do_tick(lat);
            e = (SLEW != 0) ? ((32767 - 64 * k < 8192) ? 8192 : 32767 - 64 * k) : 8192;
            check("gain_fall", {16'd0, gain}, e);
        end

        // ticks at N and N+5: both accepted, no overrun
        v1 = 0; v2 = 0;
        sample_tick = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step_cyc();
            sample_tick = (c == 5);
            if (param_valid) begin
                if (v1 == 0) v1 = c; else v2 = c;
            end
        end
        check("n5_first",   v1, 32'd4);
        check("n5_second",  v2, 32'd9);
        check("n5_overrun", {31'd0, overrun}, 32'd0);

        // ticks at N and N+2: second ignored, overrun sticky
        v1 = 0; v2 = 0;
        sample_tick = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step_cyc();
            sample_tick = (c == 2);
            if (param_valid) begin
                if (v1 == 0) v1 = c; else v2 = c;
            end
        end
        check("n2_first",   v1, 32'd4);
        check("n2_none",    v2, 32'd0);
        check("n2_overrun", {31'd0, overrun}, 32'd1);
        do_tick(lat);
        check("ovr_lat",    lat, 32'd4);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // reset at N+2 aborts the sequence
        nv = 0;
        sample_tick = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step_cyc();
            sample_tick = 1'b0;
            reset = (c == 2);
            if (param_valid) nv++;
        end
        check("abort_valid", nv, 32'd0);
        check("abort_car",   carrier_fcw, 32'd18898);
        check("abort_mod",   mod_fcw, 32'd9449);
        check("abort_gain",  {16'd0, gain}, 32'd0);
        check("abort_ovr",   {31'd0, overrun}, 32'd0);

        // reset and tick in the same cycle: tick discarded
        nv = 0;
        reset = 1'b1; sample_tick = 1'b1;
        step_cyc();
        reset = 1'b0; sample_tick = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step_cyc();
            if (param_valid) nv++;
        end
        check("rt_valid", nv, 32'd0);
        check("rt_ovr",   {31'd0, overrun}, 32'd0);

        // upper saturation on the modulator
        carrier_offset = 32'd0; mod_fcw_offset = 32'h7FFF_FFFF; vol_step = 2'd0;
        do_tick(lat);
        check("sat_lat",  lat, 32'd4);
        check("sat_mod",  mod_fcw, (SLEW != 0) ? 32'd9513 : 32'h7FFF_FFFF);
        check("sat_car",  carrier_fcw, 32'd18898);
        check("sat_gain", {16'd0, gain}, (SLEW != 0) ? 32'd64 : 32'h2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
